// File: rtl/ram512_arb_pkg.sv
// Shared widths, port ids and a one-hot helper for the RAM512 arbiter.
// Imported by the round-robin picker and the arbiter top level.
package ram512_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic [1:0] port_onehot(input logic p);
        return (p == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram512_arbiter_if.sv
// One requester port of the RAM512 arbiter: request beat plus read response.
// master = requester side, slave = arbiter side; lock exists with RAM512_ARB_BURST_EN.
interface ram512_arbiter_if #(
    parameter int AW = ram512_arb_pkg::ADDR_W,
    parameter int DW = ram512_arb_pkg::DATA_W
);
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
`ifdef RAM512_ARB_BURST_EN
    logic          lock;
`endif
    logic          ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

`ifdef RAM512_ARB_BURST_EN
    modport master (
        output valid, we, addr, wdata, lock,
        input  ready, rsp_valid, rsp_data
    );
    modport slave (
        input  valid, we, addr, wdata, lock,
        output ready, rsp_valid, rsp_data
    );
`else
    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_data
    );
    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_data
    );
`endif

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: valid_i, last_grant_i, hold_i -> one-hot grant_o.
// hold_i keeps priority on last_grant_i while that port still has a beat.
module rr_arbiter2
    import ram512_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       hold_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (hold_i && valid_i[last_grant_i]) begin
            grant_o = port_onehot(last_grant_i);
        end else if (&valid_i) begin
            grant_o = port_onehot(~last_grant_i);
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/ram512_arbiter.sv
// Shares one RAM512 between two requesters, one beat per cycle, round robin.
// Ports: clk, rst_n, p0_if/p1_if (requesters), ram_in/ram_addr/ram_load/ram_out.
// RAM512_ARB_BURST_EN adds lock-driven bursts of up to MAX_BURST beats.
module ram512_arbiter #(
    parameter int ADDR_W    = ram512_arb_pkg::ADDR_W,
    parameter int DATA_W    = ram512_arb_pkg::DATA_W
`ifdef RAM512_ARB_BURST_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    ram512_arbiter_if.slave   p0_if,
    ram512_arbiter_if.slave   p1_if,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);
    import ram512_arb_pkg::*;

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic [1:0]        we;
    logic [1:0]        rd_acc;
    logic              hold;

    logic              last_grant_q, last_grant_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

    assign valid = {p1_if.valid, p0_if.valid};
    assign we    = {p1_if.we, p0_if.we};

    rr_arbiter2 u_rr (
        .valid_i      (valid),
        .last_grant_i (last_grant_q),
        .hold_i       (hold),
        .grant_o      (grant)
    );

    // Nothing may be accepted or written while reset is held.
    assign ready  = grant & {2{rst_n}};
    assign rd_acc = ready & ~we;

    assign p0_if.ready = ready[0];
    assign p1_if.ready = ready[1];

    // Idle cycles leave port 0's fields on the RAM bus.
    assign ram_addr = grant[1] ? p1_if.addr  : p0_if.addr;
    assign ram_in   = grant[1] ? p1_if.wdata : p0_if.wdata;
    assign ram_load = |(ready & we);

    always_comb begin
        last_grant_d = last_grant_q;
        if (|ready) begin
            last_grant_d = ready[1];
        end
        rsp_valid_d = rd_acc;
        rsp0_data_d = rd_acc[0] ? ram_out : rsp0_data_q;
        rsp1_data_d = rd_acc[1] ? ram_out : rsp1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT1;
            rsp_valid_q  <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign p0_if.rsp_valid = rsp_valid_q[0];
    assign p1_if.rsp_valid = rsp_valid_q[1];
    assign p0_if.rsp_data  = rsp0_data_q;
    assign p1_if.rsp_data  = rsp1_data_q;

`ifdef RAM512_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] base;
    logic          lock_acc;

    // A nonzero count means last_grant_q is mid-burst.
    assign hold = (cnt_q != '0);

    always_comb begin
        // Only the holder continues its count; anyone else starts afresh.
        base     = (hold && ready[last_grant_q]) ? cnt_q : '0;
        lock_acc = (ready[0] & p0_if.lock) | (ready[1] & p1_if.lock);
        cnt_d    = '0;
        if (lock_acc && (int'(base) + 1 < MAX_BURST)) begin
            cnt_d = base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_ram512_arbiter.sv
// Bench for ram512_arbiter: RAM512 model, directed and random traffic,
// shadow-memory scoreboard with per-cycle grant and response checks.
module tb_ram512_arbiter;
    import ram512_arb_pkg::*;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram512_arbiter_if p0_if ();
    ram512_arbiter_if p1_if ();

    logic [15:0] ram_in;
    logic [15:0] ram_out;
    logic [8:0]  ram_addr;
    logic        ram_load;

    ram512_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0_if    (p0_if),
        .p1_if    (p1_if),
        .ram_in   (ram_in),
        .ram_addr (ram_addr),
        .ram_load (ram_load),
        .ram_out  (ram_out)
    );

    // The RAM512 itself: combinational read, write on the clock edge.
    logic [15:0] mem [512];
    assign ram_out = mem[ram_addr];
    always @(posedge clk) if (ram_load) mem[ram_addr] <= ram_in;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] pool [8] = '{9'h000, 9'h1FF, 9'h040, 9'h1A5,
                             9'h003, 9'h0AA, 9'h155, 9'h100};

    // Reference model state
    logic [15:0] ref_mem [int];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [1:0]  pend = 2'b00;
    logic        mlast = 1'b1;
    int          run = 0;
    bit          holding = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0]  v, rdy, expg, lk;
        logic        w, acc;
        logic [8:0]  a;
        logic [15:0] d;
        v   = {p1_if.valid, p0_if.valid};
        rdy = {p1_if.ready, p0_if.ready};
`ifdef RAM512_ARB_BURST_EN
        lk = {p1_if.lock, p0_if.lock};
`else
        lk = 2'b00;
`endif
        if (!rst_n) begin
            chk("rst_ready", 32'(rdy), 0);
            chk("rst_load", 32'(ram_load), 0);
            chk("rst_rsp_valid", 32'({p1_if.rsp_valid, p0_if.rsp_valid}), 0);
            chk("rst_rsp0_data", 32'(p0_if.rsp_data), 0);
            chk("rst_rsp1_data", 32'(p1_if.rsp_data), 0);
            pend = 2'b00;
            q0.delete();
            q1.delete();
            mlast = 1'b1;
            run = 0;
            holding = 0;
        end else begin
            chk("rsp0_valid", 32'(p0_if.rsp_valid), 32'(pend[0]));
            chk("rsp1_valid", 32'(p1_if.rsp_valid), 32'(pend[1]));
            if (p0_if.rsp_valid) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
                else chk("rsp0_data", 32'(p0_if.rsp_data), 32'(q0.pop_front()));
            end
            if (p1_if.rsp_valid) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
                else chk("rsp1_data", 32'(p1_if.rsp_data), 32'(q1.pop_front()));
            end
            if (holding && v[mlast]) expg = mlast ? 2'b10 : 2'b01;
            else if (v == 2'b11) expg = mlast ? 2'b01 : 2'b10;
            else expg = v;
            chk("grant", 32'(rdy), 32'(expg));
            pend = 2'b00;
            acc = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (v[p] && rdy[p]) begin
                    w = (p == 1) ? p1_if.we : p0_if.we;
                    a = (p == 1) ? p1_if.addr : p0_if.addr;
                    d = (p == 1) ? p1_if.wdata : p0_if.wdata;
                    if (w) begin
                        ref_mem[int'(a)] = d;
                    end else begin
                        if (p == 0) q0.push_back(ref_mem[int'(a)]);
                        else q1.push_back(ref_mem[int'(a)]);
                        pend[p] = 1'b1;
                    end
                    if (lk[p]) begin
                        run = (holding && (p == int'(mlast))) ? run + 1 : 1;
                        holding = (run < MB);
                    end else begin
                        run = 0;
                        holding = 0;
                    end
                    mlast = (p == 1);
                    acc = 1'b1;
                end
            end
            if (!acc) begin
                run = 0;
                holding = 0;
            end
        end
    end

    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [8:0] a, input logic [15:0] d,
                            input logic lk);
        if (p == 0) begin
            p0_if.valid = v; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
`ifdef RAM512_ARB_BURST_EN
            p0_if.lock = lk;
`endif
        end else begin
            p1_if.valid = v; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
`ifdef RAM512_ARB_BURST_EN
            p1_if.lock = lk;
`endif
        end
        if (lk) begin end
    endtask

    // Issue one beat at posedge+1, hold until accepted, return at posedge+1.
    task automatic req(input int p, input logic we, input logic [8:0] a,
                       input logic [15:0] d, input logic lk);
        bit got;
        got = 0;
        set_port(p, 1'b1, we, a, d, lk);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (p == 0) got = p0_if.ready;
            else got = p1_if.ready;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout: port %0d got no ready, required within 20 cycles", p);
        end
        @(posedge clk);
        #1;
        set_port(p, 1'b0, 1'b0, a, d, 1'b0);
    endtask

    task automatic rand_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                req(p, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                    16'($urandom), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    int c0;

    initial begin
        set_port(0, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0);
        set_port(1, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read-back on the very next cycle
        req(0, 1'b1, 9'h1A5, 16'hBEEF, 1'b0);
        req(0, 1'b0, 9'h1A5, 16'h0, 1'b0);

        for (int i = 0; i < 8; i++) req(i % 2, 1'b1, pool[i], 16'($urandom), 1'b0);

        // Continuous contention: reads alternate 0,1,0,1
        fork
            repeat (4) req(0, 1'b0, 9'h000, 16'h0, 1'b0);
            repeat (4) req(1, 1'b0, 9'h1FF, 16'h0, 1'b0);
        join

        // Same-cycle write/read to one address
        fork
            req(0, 1'b1, 9'h040, 16'h1234, 1'b0);
            req(1, 1'b0, 9'h040, 16'h0, 1'b0);
        join

        // Reset while a read is in flight
        set_port(0, 1'b1, 1'b0, 9'h1A5, 16'h0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            req(0, 1'b0, 9'h1A5, 16'h0, 1'b0);
            req(1, 1'b0, 9'h040, 16'h0, 1'b0);
        join

        // Lone port 1 streams without bubbles
        c0 = cyc;
        for (int i = 0; i < 10; i++)
            req(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                16'($urandom), 1'b0);
        chk("p1_stream_cycles", 32'(cyc - c0), 10);

`ifdef RAM512_ARB_BURST_EN
        fork
            repeat (6) req(1, 1'b0, 9'h1FF, 16'h0, 1'b1);
            repeat (6) req(0, 1'b0, 9'h000, 16'h0, 1'b0);
        join
`endif

        fork
            rand_port(0, 150);
            rand_port(1, 150);
        join

        repeat (3) @(posedge clk);
        #1;
        chk("drain0", 32'(q0.size()), 0);
        chk("drain1", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
